aes_sub_bytes_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_sbox_lane.sv | 19 +
 rtl/aes_sub_bytes_seq.sv | 117 +++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and lookup tables for the AES SubBytes datapath.
// Tables are packed [0:255] so that TABLE[x] returns the S-box value of byte x.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_state_t;

    // Each 128-bit row holds 16 consecutive entries, lowest index leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational S-box lookup; the inverse table is only built
// when SUBBYTES_INV_EN is defined, otherwise mode is ignored.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic  mode,
    input  byte_t in_byte,
    output byte_t out_byte
);

`ifdef SUBBYTES_INV_EN
    assign out_byte = mode ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign out_byte    = SBOX[in_byte];
`endif

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Folded AES SubBytes: LANES S-box lookups per cycle over the 128-bit state,
// valid/ready on both sides. Define SUBBYTES_INV_EN to enable the inverse S-box.
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
        $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_state_t    state;
    logic [CW-1:0] cnt;
    state_t        work;
    logic          mode;
    state_t        sub_work;
    byte_t         lane_in  [LANES];
    byte_t         lane_out [LANES];

    // Lane j handles byte cnt*LANES + j; byte 0 lives in the MSBs.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_in[j] = work[127 - 8*(int'(cnt)*LANES + j) -: 8];

        aes_sbox_lane u_lane (
            .mode     (mode),
            .in_byte  (lane_in[j]),
            .out_byte (lane_out[j])
        );
    end

    always_comb begin
        sub_work = work;
        for (int j = 0; j < LANES; j++) begin
            sub_work[127 - 8*(int'(cnt)*LANES + j) -: 8] = lane_out[j];
        end
    end

`ifndef SUBBYTES_INV_EN
    logic unused_inv;
    assign unused_inv = in_inv;
    assign mode       = 1'b0;
`endif

    // cnt wraps to 0 on the last chunk so it never exceeds N-1, even when N=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
`ifdef SUBBYTES_INV_EN
            mode      <= 1'b0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
`ifdef SUBBYTES_INV_EN
                        mode     <= in_inv;
`endif
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    work <= sub_work;
                    if (cnt == CW'(N - 1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = work;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Scoreboard bench for aes_sub_bytes_seq: LANES=4 main instance plus a
// LANES sweep (1, 2, 8, 16); inverse vectors used when SUBBYTES_INV_EN is defined.
module tb_aes_sub_bytes_seq;

    localparam logic [127:0] KAT_IN  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    localparam logic [127:0] KAT_OUT = 128'hd4e0b81e27bfb44111985d52aef1e530;
    localparam logic [127:0] SW_IN   = 128'ha4686b029c9f5b6a7f35ea50f22b4349;
    localparam logic [127:0] SW_OUT  = 128'h49457f77dedb3902d296875389f11a3b;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_16  = {16{8'h16}};
    localparam int SW_LANES [4] = '{1, 2, 8, 16};
    localparam int SW_LAT   [4] = '{16, 8, 2, 1};

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         sw_valid_in;
    logic [127:0] sw_data_in;
    wire  [3:0]   sw_ready;
    wire  [3:0]   sw_out_valid;
    wire  [3:0]   sw_busy;
    wire  [127:0] sw_out_data [4];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   accept_cyc = 0;
    int   prev_accept = 0;
    int   accepts = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aes_sub_bytes_seq #(.LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        aes_sub_bytes_seq #(.LANES(SW_LANES[g])) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_valid_in),
            .in_ready  (sw_ready[g]),
            .in_data   (sw_data_in),
            .in_inv    (1'b0),
            .out_valid (sw_out_valid[g]),
            .out_ready (1'b1),
            .out_data  (sw_out_data[g]),
            .busy      (sw_busy[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Holds in_valid until the engine takes the block, then scrambles the
    // inputs so a design that keeps sampling them would corrupt the result.
    task automatic applyStimulus(input logic [127:0] d, input logic inv,
                                 input logic [127:0] exp, input int lat);
        int waited = 0;
        sb_q.push_back('{data: exp, lat: lat});
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_inv   = ~inv;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain_timeout", 128'(sb_q.size()), 128'(0));
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Sampled on the falling edge: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (in_valid && in_ready) begin
            prev_accept = accept_cyc;
            accept_cyc  = cyc + 1;
            accepts++;
        end
        if (out_valid && !prev_valid) begin
            if (sb_q.size() == 0) checkOutput("unexpected_out", 128'(1), 128'(0));
            else checkOutput("latency", 128'(cyc - accept_cyc), 128'(sb_q[0].lat));
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_handshake", 128'(1), 128'(0));
            end else begin
                e = sb_q.pop_front();
                checkOutput("data", out_data, e.data);
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int t0;
        int lat [4];
        logic [3:0] seen;

        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_inv      = 1'b0;
        out_ready   = 1'b1;
        sw_valid_in = 1'b0;
        sw_data_in  = '0;
        #2 rst_n = 1'b0;

        @(negedge clk);
        checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_busy",      128'(busy),      128'(0));
        checkOutput("rst_out_data",  out_data,        128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] forward known-answer, LANES=4");
        applyStimulus(KAT_IN, 1'b0, KAT_OUT, 4);
        @(negedge clk);
        checkOutput("busy_high",     128'(busy),     128'(1));
        checkOutput("in_ready_busy", 128'(in_ready), 128'(0));
        waitDrain();

`ifdef SUBBYTES_INV_EN
        $display("[TB] inverse mode");
        applyStimulus(KAT_OUT, 1'b1, KAT_IN, 4);
        waitDrain();
        applyStimulus(128'(0), 1'b1, {16{8'h52}}, 4);
        waitDrain();
`else
        $display("[TB] forward-only build ignores in_inv");
        applyStimulus(KAT_IN, 1'b1, KAT_OUT, 4);
        waitDrain();
`endif

        $display("[TB] back-to-back blocks");
        applyStimulus(SW_IN, 1'b0, SW_OUT, 4);
        applyStimulus(KAT_IN, 1'b0, KAT_OUT, 4);
        checkOutput("b2b_gap", 128'(accept_cyc - prev_accept), 128'(6));
        waitDrain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(128'(0), 1'b0, ALL_63, 4);
        in_data  = {16{8'hff}};
        in_inv   = 1'b0;
        in_valid = 1'b1;
        base     = accepts;
        n        = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
            checkOutput("bp_out_data",  out_data,        ALL_63);
            checkOutput("bp_in_ready",  128'(in_ready),  128'(0));
        end
        checkOutput("bp_no_accept", 128'(accepts - base), 128'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus({16{8'hff}}, 1'b0, ALL_16, 4);
        waitDrain();

        $display("[TB] reset in the middle of a block");
        applyStimulus(KAT_IN, 1'b0, KAT_OUT, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst_out_data",  out_data,        128'(0));
        checkOutput("midrst_in_ready",  128'(in_ready),  128'(1));
        checkOutput("midrst_busy",      128'(busy),      128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(SW_IN, 1'b0, SW_OUT, 4);
        waitDrain();

        $display("[TB] LANES sweep");
        sw_data_in  = SW_IN;
        sw_valid_in = 1'b1;
        @(negedge clk);
        checkOutput("sw_ready", 128'(sw_ready), 128'(4'hf));
        @(posedge clk);
        #1;
        t0          = cyc;
        sw_valid_in = 1'b0;
        sw_data_in  = '0;
        seen        = '0;
        for (int g = 0; g < 4; g++) lat[g] = -1;
        @(negedge clk);
        checkOutput("sw_busy", 128'(sw_busy), 128'(4'hf));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = cyc - t0;
                    checkOutput($sformatf("sw_data_lanes%0d", SW_LANES[g]), sw_out_data[g], SW_OUT);
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            checkOutput($sformatf("sw_latency_lanes%0d", SW_LANES[g]), 128'(lat[g]), 128'(SW_LAT[g]));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
